// File: rtl/phase_shifter_pkg.sv
// Shared definitions for the phase-shifter top: code width, sequencer states
// and the shortest-path direction helper.
package phase_shifter_pkg;

  localparam int unsigned PH_W = 5;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  // 1 = step up, 0 = step down; the half-circle tie resolves upward.
  function automatic logic ph_dir(input logic [PH_W-1:0] target,
                                  input logic [PH_W-1:0] cur);
    logic [PH_W-1:0] diff;
    diff = target - cur;
    return (diff <= PH_W'(2 ** (PH_W - 1)));
  endfunction

endpackage

// File: rtl/coarse_phase_sequencer.sv
// Ramps the coarse phase code one tick at a time toward phaseTarget, holding
// each code for SETTLE_CYCLES extra clk40 cycles before the next step.
module coarse_phase_sequencer #(
  parameter int unsigned     PH_W          = phase_shifter_pkg::PH_W,
  parameter int unsigned     SETTLE_CYCLES = 15,
  parameter logic [PH_W-1:0] RESET_VAL     = '0
) (
  input  logic            clk40,
  input  logic            rst,
  input  logic            enable,
  input  logic [PH_W-1:0] phaseTarget,
  output logic [PH_W-1:0] setVal,
  output logic            busy,
  output logic            donePulse,
  output logic            stepDir
);

  localparam int unsigned      CNT_W      = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES);

  phase_shifter_pkg::state_t state_q;
  logic [PH_W-1:0]  setval_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dir_q;

  logic             mismatch;
  logic             dir_d;
  logic             step_ok;
  logic [PH_W-1:0]  step_d;

  always_comb begin
    mismatch = (setval_q != phaseTarget);
    dir_d    = phase_shifter_pkg::ph_dir(phaseTarget, setval_q);
    step_d   = dir_d ? (setval_q + PH_W'(1)) : (setval_q - PH_W'(1));
    step_ok  = enable && mismatch;
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      state_q  <= phase_shifter_pkg::IDLE;
      setval_q <= RESET_VAL;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        phase_shifter_pkg::IDLE: begin
          if (step_ok) begin
            setval_q <= step_d;
            dir_q    <= dir_d;
            cnt_q    <= CNT_RELOAD;
            state_q  <= phase_shifter_pkg::SETTLE;
            busy_q   <= 1'b1;
          end
        end
        phase_shifter_pkg::SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (step_ok) begin
            // Back-to-back step: stay busy so a ramp never drops to IDLE between codes.
            setval_q <= step_d;
            dir_q    <= dir_d;
            cnt_q    <= CNT_RELOAD;
          end else begin
            state_q <= phase_shifter_pkg::IDLE;
            busy_q  <= 1'b0;
            done_q  <= !mismatch;
          end
        end
        default: begin
          state_q <= phase_shifter_pkg::IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign setVal    = setval_q;
  assign busy      = busy_q;
  assign donePulse = done_q;
  assign stepDir   = dir_q;

endmodule

// File: tb/tb_coarse_phase_sequencer.sv
// Directed bench for coarse_phase_sequencer: table-driven ramps plus hand
// sequences for reversal, enable drop, mid-settle reset and a random soak.
module tb_coarse_phase_sequencer;

  localparam int SETTLE = 4;
  localparam int PERIOD = SETTLE + 1;

  logic       clk40 = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] phaseTarget = '0;
  logic [4:0] setVal;
  logic       busy, donePulse, stepDir;

  logic       z_enable = 1'b0;
  logic [4:0] z_target = '0;
  logic [4:0] z_setVal;
  logic       z_busy, z_done, z_dir;

  int n_cmp = 0;
  int n_fail = 0;

  logic [4:0] prev_sv;
  logic       have_prev = 1'b0;

  always #5 clk40 = ~clk40;

  coarse_phase_sequencer #(.PH_W(5), .SETTLE_CYCLES(SETTLE), .RESET_VAL(5'd0)) dut (
    .clk40(clk40), .rst(rst), .enable(enable), .phaseTarget(phaseTarget),
    .setVal(setVal), .busy(busy), .donePulse(donePulse), .stepDir(stepDir)
  );

  coarse_phase_sequencer #(.PH_W(5), .SETTLE_CYCLES(0), .RESET_VAL(5'd0)) dut_z (
    .clk40(clk40), .rst(rst), .enable(z_enable), .phaseTarget(z_target),
    .setVal(z_setVal), .busy(z_busy), .donePulse(z_done), .stepDir(z_dir)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every clock advance goes through here so the one-tick-per-edge invariant is always checked.
  task automatic tick();
    logic       r;
    logic [4:0] d;
    @(posedge clk40);
    r = rst;
    #1;
    if (!r && have_prev) begin
      d = setVal - prev_sv;
      chk("step_le_1", int'(d == 5'd0 || d == 5'd1 || d == 5'd31), 1);
    end
    prev_sv   = setVal;
    have_prev = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_code(input logic [4:0] code, input string name);
    for (int i = 0; i < 200 && setVal != code; i++) tick();
    chk(name, int'(setVal), int'(code));
  endtask

  typedef struct {
    logic [4:0] target;
    logic       en;
    int         steps;
    logic [4:0] fin;
    logic       dir;
    int         dones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vec_t       v;
    int         seen, dn, cyc, maxv;
    logic [4:0] last;

    vecs[0] = '{5'd3,  1'b1, 3,  5'd3,  1'b1, 1};  // plain upward ramp
    vecs[1] = '{5'd2,  1'b1, 1,  5'd2,  1'b0, 1};  // single step down
    vecs[2] = '{5'd30, 1'b1, 4,  5'd30, 1'b0, 1};  // down through 0 -> 31
    vecs[3] = '{5'd1,  1'b1, 3,  5'd1,  1'b1, 1};  // up through 31 -> 0
    vecs[4] = '{5'd1,  1'b1, 0,  5'd1,  1'b1, 0};  // already on target
    vecs[5] = '{5'd0,  1'b1, 1,  5'd0,  1'b0, 1};
    vecs[6] = '{5'd16, 1'b1, 16, 5'd16, 1'b1, 1};  // half-circle tie goes up

    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_setVal", int'(setVal), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(donePulse), 0);
    chk("rst_stepDir", int'(stepDir), 1);
    rst = 1'b0;

    // Zero-settle instance: one step per cycle, busy held through the ramp.
    z_target = 5'd3;
    z_enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("z_setVal", int'(z_setVal), (k < 4) ? k : 3);
      chk("z_busy", int'(z_busy), (k < 4) ? 1 : 0);
      chk("z_done", int'(z_done), (k < 4) ? 0 : 1);
    end
    tick();
    chk("z_done_once", int'(z_done), 0);

    for (int n = 0; n < 7; n++) begin
      v = vecs[n];
      phaseTarget = v.target;
      enable = v.en;
      last = setVal;
      seen = 0;
      dn = 0;
      cyc = PERIOD * v.steps + 4;
      for (int c = 1; c <= cyc; c++) begin
        tick();
        if (setVal != last) begin
          chk($sformatf("v%0d_step_time", n), c, 1 + PERIOD * seen);
          seen++;
          last = setVal;
        end
        if (donePulse) begin
          chk($sformatf("v%0d_done_time", n), c, PERIOD * v.steps + 1);
          dn++;
        end
      end
      chk($sformatf("v%0d_steps", n), seen, v.steps);
      chk($sformatf("v%0d_setVal", n), int'(setVal), int'(v.fin));
      chk($sformatf("v%0d_stepDir", n), int'(stepDir), int'(v.dir));
      chk($sformatf("v%0d_busy", n), int'(busy), 0);
      chk($sformatf("v%0d_dones", n), dn, v.dones);
    end

    // Enable low with a pending target: nothing happens.
    phaseTarget = 5'd20;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("en0_setVal", int'(setVal), 16);
    chk("en0_busy", int'(busy), 0);

    // Reversal: retarget from 5 to 2 while sitting at 4.
    do_reset();
    phaseTarget = 5'd5;
    enable = 1'b1;
    wait_code(5'd4, "rev_reach4");
    phaseTarget = 5'd2;
    dn = 0;
    maxv = 4;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int'(setVal) > maxv) maxv = int'(setVal);
      if (donePulse) dn++;
    end
    chk("rev_max", maxv, 4);
    chk("rev_setVal", int'(setVal), 2);
    chk("rev_stepDir", int'(stepDir), 0);
    chk("rev_dones", dn, 1);

    // Enable dropped mid-settle: settle finishes, back to IDLE, no done.
    do_reset();
    phaseTarget = 5'd5;
    enable = 1'b1;
    wait_code(5'd4, "drop_reach4");
    enable = 1'b0;
    tick();
    chk("drop_busy_mid", int'(busy), 1);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (donePulse) dn++;
    end
    chk("drop_setVal", int'(setVal), 4);
    chk("drop_busy", int'(busy), 0);
    chk("drop_dones", dn, 0);

    // Reset in the middle of a settle interval.
    do_reset();
    phaseTarget = 5'd9;
    enable = 1'b1;
    wait_code(5'd7, "mrst_reach7");
    tick();
    tick();
    chk("mrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("mrst_setVal", int'(setVal), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_stepDir", int'(stepDir), 1);
    chk("mrst_done", int'(donePulse), 0);
    rst = 1'b0;

    // Random soak; the invariant check in tick() does the work.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 36) == 0) phaseTarget = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
